spectro_frame_ctrl: RTL and testbench
=====================================

SPECTRO_FRAME_CTRL -- requirements
Module: spectro_frame_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8: number of channel counters sequenced (2..16).
REQ-002 Parameter WINDOW, default 1000: integration window length in clk cycles (1..2^20-1).
REQ-003 Parameter CLR_CYC, default 2: cycles cnt_clear is held high per frame (>=1).
REQ-004 Port clk  in  1  single clock; all logic rising-edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-007 Port abort  in  1  synchronous abort; returns to IDLE from any state.
REQ-008 Port cfg_continuous  in  1  1 = start next frame automatically after readout.
REQ-009 Port cnt_clear  out  1  active-high clear to all channel counters.
REQ-010 Port cnt_hold  out  1  1 = counters frozen (drives counter enable; counters count when 0).
REQ-011 Port ch_sel  out  $clog2(NUM_CH)  channel counter selected for readout.
REQ-012 Port cnt_data  in  12  selected counter value.
REQ-013 Port cnt_ovf  in  1  selected counter overflow flag.
REQ-014 Port out_valid / out_ready  out / in  1 / 1  readout handshake.
REQ-015 Port out_data  out  12  sampled count; out_ch  out  $clog2(NUM_CH); out_ovf  out  1; out_last  out  1 (final channel of frame).
REQ-016 Port busy  out  1  high in every state except IDLE; frame_cnt  out  8  completed-frame count.

Function
REQ-017 FSM states: IDLE, CLEAR, INTEGRATE, SETTLE, SELECT, PRESENT.
REQ-018 IDLE: cnt_hold=1, cnt_clear=0, out_valid=0; start=1 -> CLEAR next cycle.
REQ-019 CLEAR: cnt_clear=1, cnt_hold=1 for exactly CLR_CYC cycles -> INTEGRATE.
REQ-020 INTEGRATE: cnt_hold=0, cnt_clear=0 for exactly WINDOW cycles -> SETTLE.
REQ-021 SETTLE: cnt_hold=1 for 2 cycles (impulse-domain quiescence) -> SELECT with ch_sel=0.
REQ-022 SELECT: one cycle with ch_sel stable; at its end sample cnt_data, cnt_ovf, ch_sel into out_data, out_ovf, out_ch -> PRESENT.
REQ-023 PRESENT: out_valid=1; out_data/out_ch/out_ovf/out_last stable until out_valid&out_ready.
REQ-024 Transfer on non-last channel: ch_sel+1, -> SELECT; out_valid low for exactly one cycle between words.
REQ-025 Transfer with out_last=1: frame_cnt+1 (wraps 255->0); cfg_continuous=1 -> CLEAR, else -> IDLE.
REQ-026 out_last=1 iff out_ch==NUM_CH-1 while out_valid.
REQ-027 cnt_hold=1 in all states except INTEGRATE; cnt_clear=1 only in CLEAR.
REQ-028 start outside IDLE ignored, not queued; start and abort same cycle: abort wins.
REQ-029 abort: next cycle IDLE, out_valid=0, ch_sel=0, frame_cnt unchanged; aborted frame emits no further words.
REQ-030 cfg_continuous sampled only at the final transfer; changes elsewhere have no effect on the current frame.

Reset
REQ-031 rst_n low: state IDLE, cnt_hold=1, cnt_clear=0, ch_sel=0, out_valid=0, out_data=0, out_ch=0, out_ovf=0, out_last=0, frame_cnt=0, timers=0, busy=0.
REQ-032 Reset mid-frame discards the frame; first frame after release requires start.

Configuration
REQ-033 Macro SPECTRO_SATURATE_EN defined: when sampled cnt_ovf=1, out_data=4095 (saturated), out_ovf=1.
REQ-034 Macro undefined: out_data = raw cnt_data (wrapped), out_ovf = cnt_ovf.

Structure
REQ-035 Package spectro_pkg holds CNT_W=12, FRAME_CNT_W=8, SETTLE_CYC=2 and the FSM state enum.
REQ-036 One sub-module, spectro_window_timer: loadable down-counter shared by CLEAR, INTEGRATE, SETTLE, asserting done on terminal count.

Verification
REQ-037 NUM_CH=4, WINDOW=10: start pulse -> cnt_clear high 2 cycles, cnt_hold low exactly 10 cycles, 4 words ch 0..3, out_last on ch 3, frame_cnt=1, IDLE.
REQ-038 out_ready low 5 cycles on ch 1 -> out_data/out_ch held stable, no word lost or duplicated.
REQ-039 cnt_data=4095 with cnt_ovf=1 on ch 2 -> out_data=4095, out_ovf=1 with macro; raw value without.
REQ-040 cfg_continuous=1, ready always high -> 3 back-to-back frames, CLEAR follows final transfer next cycle, frame_cnt=3.
REQ-041 abort during INTEGRATE and during PRESENT of ch 2 -> IDLE next cycle, out_valid=0, cnt_hold=1, frame_cnt unchanged.
REQ-042 rst_n low during SETTLE, start during busy -> all outputs at reset values; extra start ignored.

Source files
------------

// File: rtl/spectro_pkg.sv
// Shared constants and FSM encoding for the spectrometer frame controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spectro_pkg;

  localparam int CNT_W       = 12;
  localparam int FRAME_CNT_W = 8;
  localparam int SETTLE_CYC  = 2;
  localparam int TMR_W       = 20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_INTEGRATE = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_SELECT    = 3'd4,
    ST_PRESENT   = 3'd5
  } state_e;

endpackage

// File: rtl/spectro_window_timer.sv
// Loadable down-counter timing the CLEAR, INTEGRATE and SETTLE phases.
// Latency: load takes effect next cycle; done is combinational on count==0.
// Backpressure: none; counts freely and parks at zero.
module spectro_window_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/spectro_frame_ctrl.sv
// Frame sequencer: clear, integrate, settle, then read out NUM_CH counters.
// Latency: word sampled at end of SELECT, presented next cycle; 1 idle cycle between words.
// Backpressure: PRESENT holds its word until out_ready; optional saturation via SPECTRO_SATURATE_EN.
module spectro_frame_ctrl
  import spectro_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int WINDOW  = 1000,
  parameter int CLR_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       cfg_continuous,
  output logic                       cnt_clear,
  output logic                       cnt_hold,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  input  logic [CNT_W-1:0]           cnt_data,
  input  logic                       cnt_ovf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       out_ovf,
  output logic                       out_last,
  output logic                       busy,
  output logic [FRAME_CNT_W-1:0]     frame_cnt
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] CLR_LD  = TMR_W'(CLR_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LD  = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SET_LD  = TMR_W'(SETTLE_CYC - 1);

  state_e            state;
  state_e            state_n;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              xfer;
  logic              sel_last;
  logic [CNT_W-1:0]  sample_data;

  spectro_window_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign xfer     = (state == ST_PRESENT) && out_ready;
  assign sel_last = (ch_sel == LAST_CH);

`ifdef SPECTRO_SATURATE_EN
  assign sample_data = cnt_ovf ? {CNT_W{1'b1}} : cnt_data;
`else
  assign sample_data = cnt_data;
`endif

  // Next-state and timer reload; abort overrides every other transition.
  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = CLR_LD;
        end
      end
      ST_CLEAR: begin
        if (tmr_done) begin
          state_n  = ST_INTEGRATE;
          tmr_load = 1'b1;
          tmr_val  = WIN_LD;
        end
      end
      ST_INTEGRATE: begin
        if (tmr_done) begin
          state_n  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SET_LD;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) state_n = ST_SELECT;
      end
      ST_SELECT: begin
        state_n = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (sel_last) begin
            // Continuous mode is only looked at on the final word of a frame.
            if (cfg_continuous) begin
              state_n  = ST_CLEAR;
              tmr_load = 1'b1;
              tmr_val  = CLR_LD;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            state_n = ST_SELECT;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort) begin
      state_n  = ST_IDLE;
      tmr_load = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Channel pointer: zeroed on entry to readout, stepped on each non-final transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel <= '0;
    end else if (abort) begin
      ch_sel <= '0;
    end else if (state == ST_SETTLE && tmr_done) begin
      ch_sel <= '0;
    end else if (xfer) begin
      ch_sel <= sel_last ? '0 : ch_sel + 1'b1;
    end
  end

  // Capture the selected counter at the end of SELECT; held through PRESENT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
      out_ovf  <= 1'b0;
    end else if (state == ST_SELECT && !abort) begin
      out_data <= sample_data;
      out_ch   <= ch_sel;
      out_ovf  <= cnt_ovf;
    end
  end

  // Completed-frame counter, bumped on the final transfer; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (xfer && sel_last && !abort) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign out_valid = (state == ST_PRESENT);
  assign out_last  = out_valid && (out_ch == LAST_CH);
  assign cnt_clear = (state == ST_CLEAR);
  assign cnt_hold  = (state != ST_INTEGRATE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_spectro_frame_ctrl.sv
// Directed bench for spectro_frame_ctrl with an expected-word scoreboard.
// Latency: n/a (testbench).
// Backpressure: bench drives out_ready, including stall windows.
module tb_spectro_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        cfg_continuous;
  logic        cnt_clear;
  logic        cnt_hold;
  logic [1:0]  ch_sel;
  logic [11:0] cnt_data;
  logic        cnt_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_ch;
  logic        out_ovf;
  logic        out_last;
  logic        busy;
  logic [7:0]  frame_cnt;

  typedef struct packed {
    logic [11:0] data;
    logic [1:0]  ch;
    logic        ovf;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  logic [11:0] data_tab[4];
  logic        ovf_tab[4];
  int          checks = 0;
  int          errors = 0;
  int          clr_n;
  int          hold_n;

  always #5 clk = ~clk;

  // Counter bank model: the selected channel's value appears combinationally.
  assign cnt_data = data_tab[ch_sel];
  assign cnt_ovf  = ovf_tab[ch_sel];

  spectro_frame_ctrl #(.NUM_CH(4), .WINDOW(10), .CLR_CYC(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_continuous (cfg_continuous),
    .cnt_clear      (cnt_clear),
    .cnt_hold       (cnt_hold),
    .ch_sel         (ch_sel),
    .cnt_data       (cnt_data),
    .cnt_ovf        (cnt_ovf),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_ch         (out_ch),
    .out_ovf        (out_ovf),
    .out_last       (out_last),
    .busy           (busy),
    .frame_cnt      (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_hold"},      cnt_hold,  1);
    check({pfx, "_clear"},     cnt_clear, 0);
    check({pfx, "_ch_sel"},    ch_sel,    0);
    check({pfx, "_valid"},     out_valid, 0);
    check({pfx, "_data"},      out_data,  0);
    check({pfx, "_out_ch"},    out_ch,    0);
    check({pfx, "_ovf"},       out_ovf,   0);
    check({pfx, "_last"},      out_last,  0);
    check({pfx, "_frame_cnt"}, frame_cnt, 0);
    check({pfx, "_busy"},      busy,      0);
  endtask

  task automatic set_tab(input logic [11:0] d0, d1, d2, d3, input logic [3:0] ovf);
    data_tab[0] = d0; data_tab[1] = d1; data_tab[2] = d2; data_tab[3] = d3;
    for (int i = 0; i < 4; i++) ovf_tab[i] = ovf[i];
  endtask

  task automatic push_word(input int ch);
    word_t w;
    w.ch   = 2'(ch);
    w.ovf  = ovf_tab[ch];
    w.last = (ch == 3);
`ifdef SPECTRO_SATURATE_EN
    w.data = ovf_tab[ch] ? 12'hFFF : data_tab[ch];
`else
    w.data = data_tab[ch];
`endif
    exp_q.push_back(w);
  endtask

  task automatic push_frame();
    for (int c = 0; c < 4; c++) push_word(c);
  endtask

  task automatic post_check(input logic was_last, input logic cont);
    if (was_last) begin
      check("after_last_clear", cnt_clear, cont);
      check("after_last_busy",  busy,      cont);
    end else begin
      check("gap_valid_low", out_valid, 0);
    end
  endtask

  // Drain nwords from the DUT, stalling stall_n cycles on stall_ch and
  // dropping cfg_continuous just before transfer number cont_off_word.
  task automatic collect(input int nwords, input int stall_ch, input int stall_n,
                         input int cont_off_word);
    int          got     = 0;
    int          stalled = 0;
    int          cyc     = 0;
    logic [11:0] held    = '0;
    logic        post    = 1'b0;
    logic        p_last  = 1'b0;
    logic        p_cont  = 1'b0;
    word_t       w;
    clr_n  = 0;
    hold_n = 0;
    while (got < nwords && cyc < 500) begin
      if (post) begin
        post_check(p_last, p_cont);
        post = 1'b0;
      end
      if (cnt_clear) clr_n++;
      if (!cnt_hold) hold_n++;
      out_ready = 1'b1;
      if (out_valid) begin
        if (int'(out_ch) == stall_ch && stalled < stall_n) begin
          out_ready = 1'b0;
          if (stalled == 0) held = out_data;
          else begin
            check("stall_data", out_data, held);
            check("stall_ch",   out_ch,   stall_ch);
          end
          stalled++;
        end else if (exp_q.size() == 0) begin
          check("scoreboard_size", exp_q.size(), 1);
          got = nwords;
        end else begin
          w = exp_q.pop_front();
          check("word_data", out_data, w.data);
          check("word_ch",   out_ch,   w.ch);
          check("word_ovf",  out_ovf,  w.ovf);
          check("word_last", out_last, w.last);
          if (got + 1 == cont_off_word) cfg_continuous = 1'b0;
          p_last = out_last;
          p_cont = cfg_continuous;
          post   = 1'b1;
          got++;
        end
      end
      tick();
      cyc++;
    end
    if (post) post_check(p_last, p_cont);
    check("words_received", got, nwords);
  endtask

  initial begin
    int fc;
    int n;
    int vcnt;
    int bcnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_continuous = 1'b0; out_ready = 1'b0;
    set_tab(12'd0, 12'd0, 12'd0, 12'd0, 4'b0000);

    #12;
    check_reset("reset");
    rst_n = 1'b1;
    tick(); tick();
    check("idle_after_reset_busy", busy, 0);

    // Basic frame.
    set_tab(12'd100, 12'd200, 12'd300, 12'd400, 4'b0000);
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    collect(4, -1, 0, 0);
    check("f1_clear_cycles", clr_n,     2);
    check("f1_hold_low",     hold_n,    10);
    check("f1_frame_cnt",    frame_cnt, 1);
    check("f1_busy",         busy,      0);
    check("f1_queue_empty",  exp_q.size(), 0);

    // Backpressure on ch 1 and overflowed counters on ch 2 and 3.
    set_tab(12'd11, 12'd22, 12'd4095, 12'd123, 4'b1100);
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    collect(4, 1, 5, 0);
    check("f2_frame_cnt",   frame_cnt, 2);
    check("f2_queue_empty", exp_q.size(), 0);

    // Three back-to-back continuous frames.
    set_tab(12'd1, 12'd2, 12'd3, 12'd4, 4'b0000);
    push_frame(); push_frame(); push_frame();
    cfg_continuous = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    collect(12, -1, 0, 12);
    check("cont_clear_cycles", clr_n,     6);
    check("cont_hold_low",     hold_n,    30);
    check("cont_frame_cnt",    frame_cnt, 5);
    check("cont_busy",         busy,      0);

    // Abort during INTEGRATE.
    fc = int'(frame_cnt);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (cnt_hold && n < 20) begin tick(); n++; end
    check("ab1_reached_integrate", cnt_hold, 0);
    tick(); tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("ab1_busy",      busy,      0);
    check("ab1_valid",     out_valid, 0);
    check("ab1_hold",      cnt_hold,  1);
    check("ab1_ch_sel",    ch_sel,    0);
    check("ab1_frame_cnt", frame_cnt, fc);
    vcnt = 0; bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) vcnt++;
      if (busy) bcnt++;
      tick();
    end
    check("ab1_no_words", vcnt, 0);
    check("ab1_stay_idle", bcnt, 0);

    // Abort (with a simultaneous start) during PRESENT of ch 2.
    set_tab(12'd7, 12'd8, 12'd9, 12'd10, 4'b0000);
    push_word(0); push_word(1);
    start = 1'b1; tick(); start = 1'b0;
    collect(2, -1, 0, 0);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check("ab2_present_ch", out_ch, 2);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    check("ab2_busy",      busy,      0);
    check("ab2_valid",     out_valid, 0);
    check("ab2_hold",      cnt_hold,  1);
    check("ab2_ch_sel",    ch_sel,    0);
    check("ab2_frame_cnt", frame_cnt, fc);
    vcnt = 0; bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) vcnt++;
      if (busy) bcnt++;
      tick();
    end
    check("ab2_no_words", vcnt, 0);
    check("ab2_stay_idle", bcnt, 0);

    // Extra start while busy, then reset during SETTLE.
    start = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (cnt_hold && n < 20) begin tick(); n++; end
    hold_n = 0;
    while (!cnt_hold && hold_n < 40) begin hold_n++; tick(); end
    check("rs_hold_low",     hold_n,   10);
    check("rs_settle_busy",  busy,     1);
    check("rs_settle_hold",  cnt_hold, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rs_async");
    tick();
    rst_n = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcnt++;
      tick();
    end
    check("rs_needs_start", bcnt, 0);
    check("rs_frame_cnt",   frame_cnt, 0);

    // Fresh frame after reset.
    set_tab(12'd55, 12'd66, 12'd77, 12'd2047, 4'b1000);
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    collect(4, -1, 0, 0);
    check("f4_frame_cnt",   frame_cnt, 1);
    check("f4_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
